// File: rtl/mac_pkg.sv
// Shared types and helpers for the mac_pe systolic processing element.
package mac_pkg;

    localparam int unsigned MAC_LATENCY = 3;
    localparam int unsigned MAX_ACC_W   = 64;

    typedef struct packed {
        logic valid;
        logic clear;
        logic last;
        logic is_signed;
    } beat_t;

    // Callers size-cast the result down to their own accumulator width.
    function automatic logic [MAX_ACC_W-1:0] sat_max(input int unsigned acc_w, input logic is_signed);
        if (is_signed)
            return (MAX_ACC_W'(1) << (acc_w - 1)) - MAX_ACC_W'(1);
        if (acc_w >= MAX_ACC_W)
            return '1;
        return (MAX_ACC_W'(1) << acc_w) - MAX_ACC_W'(1);
    endfunction

    function automatic logic [MAX_ACC_W-1:0] sat_min(input int unsigned acc_w, input logic is_signed);
        if (is_signed)
            return MAX_ACC_W'(1) << (acc_w - 1);
        return '0;
    endfunction

endpackage

// File: rtl/mac_acc_sat.sv
// Stage-2 accumulate: adds the extended product to the accumulator (or restarts
// on clear), detects signed/unsigned overflow and optionally saturates.
module mac_acc_sat
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W    = 32,
    parameter bit          SATURATE = 1'b1
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W-1:0] prod_ext,
    input  logic             clear,
    input  logic             is_signed,
    output logic [ACC_W-1:0] acc_next,
    output logic             ovf
);

    logic [ACC_W-1:0] addend;
    logic [ACC_W:0]   sum;

    always_comb begin
        addend   = clear ? '0 : acc;
        sum      = {1'b0, addend} + {1'b0, prod_ext};
        acc_next = sum[ACC_W-1:0];
        if (is_signed)
            ovf = (addend[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != addend[ACC_W-1]);
        else
            ovf = sum[ACC_W];
        // Signed overflow only happens with equal-sign addends, so the addend sign picks the rail.
        if (SATURATE && ovf) begin
            if (is_signed && addend[ACC_W-1])
                acc_next = ACC_W'(sat_min(ACC_W, 1'b1));
            else
                acc_next = ACC_W'(sat_max(ACC_W, is_signed));
        end
    end

endmodule

// File: rtl/mac_pe.sv
// mac_pe: systolic MAC processing element. Forwards operands east/south with
// one cycle of latency and runs a 3-stage multiply-accumulate with clear/last framing.
module mac_pe
    import mac_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ACC_W    = 32,
    parameter bit          SATURATE = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              valid_in,
    input  logic              clear_in,
    input  logic              last_in,
    input  logic              signed_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              valid_out,
    output logic              clear_out,
    output logic              last_out,
    output logic              signed_out,
    output logic [ACC_W-1:0]  res_out,
    output logic              res_valid,
    output logic              ovf
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    if (ACC_W < PROD_W) begin : g_bad_acc_w
        $error("mac_pe: ACC_W must be at least 2*DATA_W");
    end
    if (ACC_W > MAX_ACC_W) begin : g_wide_acc_w
        $error("mac_pe: ACC_W exceeds MAX_ACC_W");
    end

    beat_t             s1;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] prod_s;
    logic [PROD_W-1:0] prod_u;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  acc_next;
    logic              ovf_beat;

    // Stage 0: forwarding registers double as the first pipeline stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_out      <= '0;
            b_out      <= '0;
            valid_out  <= 1'b0;
            clear_out  <= 1'b0;
            last_out   <= 1'b0;
            signed_out <= 1'b0;
        end else begin
            valid_out  <= valid_in;
            clear_out  <= valid_in & clear_in;
            last_out   <= valid_in & last_in;
            signed_out <= valid_in & signed_in;
            if (valid_in) begin
                a_out <= a_in;
                b_out <= b_in;
            end
        end
    end

    assign prod_s = PROD_W'($signed(a_out)) * PROD_W'($signed(b_out));
    assign prod_u = PROD_W'(a_out) * PROD_W'(b_out);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1   <= '0;
            prod <= '0;
        end else begin
            s1 <= '{valid: valid_out, clear: clear_out, last: last_out, is_signed: signed_out};
            if (valid_out)
                prod <= signed_out ? prod_s : prod_u;
        end
    end

    always_comb begin
        if (s1.is_signed)
            prod_ext = ACC_W'($signed(prod));
        else
            prod_ext = ACC_W'(prod);
    end

    mac_acc_sat #(
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_acc_sat (
        .acc       (res_out),
        .prod_ext  (prod_ext),
        .clear     (s1.clear),
        .is_signed (s1.is_signed),
        .acc_next  (acc_next),
        .ovf       (ovf_beat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            res_out   <= '0;
            ovf       <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= s1.valid & s1.last;
            if (s1.valid) begin
                res_out <= acc_next;
                ovf     <= s1.clear ? ovf_beat : (ovf | ovf_beat);
            end
        end
    end

endmodule

// File: tb/tb_mac_pe.sv
// Self-checking bench for mac_pe: three configurations (32-bit saturating,
// 16-bit saturating, 16-bit wrapping) share one stimulus stream.
module tb_mac_pe;
    import mac_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a_in, b_in;
    logic       valid_in, clear_in, last_in, signed_in;

    logic [7:0]  a_o [3];
    logic [7:0]  b_o [3];
    logic        vo [3], co [3], lo [3], so [3], rv [3], ov [3];
    logic [31:0] r0;
    logic [15:0] r1, r2;
    logic [31:0] res_o [3];

    assign res_o[0] = r0;
    assign res_o[1] = {16'h0, r1};
    assign res_o[2] = {16'h0, r2};

    always #5 clk = ~clk;

    mac_pe u_dut0 (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
        .clear_in(clear_in), .last_in(last_in), .signed_in(signed_in),
        .a_out(a_o[0]), .b_out(b_o[0]), .valid_out(vo[0]), .clear_out(co[0]),
        .last_out(lo[0]), .signed_out(so[0]), .res_out(r0), .res_valid(rv[0]), .ovf(ov[0])
    );

    mac_pe #(.ACC_W(16), .SATURATE(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
        .clear_in(clear_in), .last_in(last_in), .signed_in(signed_in),
        .a_out(a_o[1]), .b_out(b_o[1]), .valid_out(vo[1]), .clear_out(co[1]),
        .last_out(lo[1]), .signed_out(so[1]), .res_out(r1), .res_valid(rv[1]), .ovf(ov[1])
    );

    mac_pe #(.ACC_W(16), .SATURATE(1'b0)) u_dut2 (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .valid_in(valid_in),
        .clear_in(clear_in), .last_in(last_in), .signed_in(signed_in),
        .a_out(a_o[2]), .b_out(b_o[2]), .valid_out(vo[2]), .clear_out(co[2]),
        .last_out(lo[2]), .signed_out(so[2]), .res_out(r2), .res_valid(rv[2]), .ovf(ov[2])
    );

    int unsigned cfg_w   [3] = '{32, 16, 16};
    bit          cfg_sat [3] = '{1'b1, 1'b1, 1'b0};

    // Reference model: accumulator held as an unsigned bit pattern, arithmetic in longint.
    longint macc [3];
    bit     movf [3];

    typedef struct packed {
        int               due;
        logic [2:0][31:0] res;
        logic [2:0]       ovf;
    } exp_t;
    exp_t expq[$];

    logic [7:0] ea, eb;
    logic       ev, ec, el, es;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void model_beat(input int i, input logic [7:0] a, input logic [7:0] b,
                                       input logic clr, input logic sgn);
        longint m, cur, p, s;
        bit o;
        m = longint'(1) << cfg_w[i];
        if (sgn) begin
            p   = longint'($signed(a)) * longint'($signed(b));
            cur = clr ? 0 : ((macc[i] >= m / 2) ? macc[i] - m : macc[i]);
            s   = cur + p;
            o   = (s > m / 2 - 1) || (s < -(m / 2));
            if (o && cfg_sat[i]) s = (s > 0) ? m / 2 - 1 : -(m / 2);
        end else begin
            p   = longint'(a) * longint'(b);
            cur = clr ? 0 : macc[i];
            s   = cur + p;
            o   = (s >= m);
            if (o && cfg_sat[i]) s = m - 1;
        end
        macc[i] = ((s % m) + m) % m;
        movf[i] = clr ? o : (movf[i] | o);
    endfunction

    task automatic tick();
        exp_t e;
        bit   due;
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            ea = '0; eb = '0; ev = 1'b0; ec = 1'b0; el = 1'b0; es = 1'b0;
            for (int i = 0; i < 3; i++) begin
                macc[i] = 0;
                movf[i] = 1'b0;
            end
            expq.delete();
        end else begin
            ev = valid_in;
            ec = valid_in & clear_in;
            el = valid_in & last_in;
            es = valid_in & signed_in;
            if (valid_in) begin
                ea = a_in;
                eb = b_in;
                for (int i = 0; i < 3; i++) model_beat(i, a_in, b_in, clear_in, signed_in);
                if (last_in) begin
                    e.due = cyc + 2;
                    for (int i = 0; i < 3; i++) begin
                        e.res[i] = 32'(macc[i]);
                        e.ovf[i] = movf[i];
                    end
                    expq.push_back(e);
                end
            end
        end
        due = (expq.size() > 0) && (expq[0].due == cyc);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("a_out[%0d]", i), a_o[i], ea);
            chk($sformatf("b_out[%0d]", i), b_o[i], eb);
            chk($sformatf("valid_out[%0d]", i), vo[i], ev);
            chk($sformatf("clear_out[%0d]", i), co[i], ec);
            chk($sformatf("last_out[%0d]", i), lo[i], el);
            chk($sformatf("signed_out[%0d]", i), so[i], es);
            chk($sformatf("res_valid[%0d]", i), rv[i], due);
            if (due) begin
                chk($sformatf("res_out[%0d]", i), res_o[i], expq[0].res[i]);
                chk($sformatf("ovf[%0d]", i), ov[i], expq[0].ovf[i]);
            end
            if (reset) begin
                chk($sformatf("reset_res[%0d]", i), res_o[i], 0);
                chk($sformatf("reset_ovf[%0d]", i), ov[i], 0);
            end
        end
        if (due) void'(expq.pop_front());
    endtask

    task automatic beat(input logic [7:0] a, input logic [7:0] b,
                        input logic clr, input logic lst, input logic sgn);
        valid_in = 1'b1; a_in = a; b_in = b; clear_in = clr; last_in = lst; signed_in = sgn;
        tick();
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b0;
            {a_in, b_in, clear_in, last_in, signed_in} = 19'($urandom);
            tick();
        end
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sgn;
        logic [31:0] e32;
        logic [15:0] e16;
    } vec_t;
    vec_t vecs [8];

    int          len;
    logic        rsgn, rclr;
    bit          big;
    logic [7:0]  ra, rb;

    initial begin
        vecs[0] = '{8'hFD, 8'h05, 1'b1, 32'hFFFF_FFF1, 16'hFFF1};
        vecs[1] = '{8'hFD, 8'h05, 1'b0, 32'd1265,      16'd1265};
        vecs[2] = '{8'h80, 8'h80, 1'b1, 32'h0000_4000, 16'h4000};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 32'd1,         16'd1};
        vecs[4] = '{8'hFF, 8'hFF, 1'b0, 32'd65025,     16'hFE01};
        vecs[5] = '{8'h7F, 8'h80, 1'b1, 32'hFFFF_C080, 16'hC080};
        vecs[6] = '{8'h00, 8'hAB, 1'b1, 32'd0,         16'd0};
        vecs[7] = '{8'h80, 8'h7F, 1'b0, 32'd16256,     16'h3F80};

        reset = 1'b1; valid_in = 1'b0; a_in = '0; b_in = '0;
        clear_in = 1'b0; last_in = 1'b0; signed_in = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        bubble(1);

        // Four contiguous unsigned beats.
        beat(8'd1, 8'd5, 1'b1, 1'b0, 1'b0);
        beat(8'd2, 8'd6, 1'b0, 1'b0, 1'b0);
        beat(8'd3, 8'd7, 1'b0, 1'b0, 1'b0);
        beat(8'd4, 8'd8, 1'b0, 1'b1, 1'b0);
        bubble(1);
        chk("t1_early_strobe", rv[0], 0);
        bubble(1);
        chk("t1_strobe", rv[0], 1);
        chk("t1_res", res_o[0], 70);
        chk("t1_ovf", ov[0], 0);
        bubble(1);
        chk("t1_single_strobe", rv[0], 0);

        // Single-product dot products from the vector table.
        foreach (vecs[k]) begin
            beat(vecs[k].a, vecs[k].b, 1'b1, 1'b1, vecs[k].sgn);
            bubble(2);
            chk($sformatf("vec%0d_strobe", k), rv[0], 1);
            chk($sformatf("vec%0d_res32", k), res_o[0], vecs[k].e32);
            chk($sformatf("vec%0d_res16s", k), res_o[1], vecs[k].e16);
            chk($sformatf("vec%0d_res16w", k), res_o[2], vecs[k].e16);
            chk($sformatf("vec%0d_ovf", k), ov[1], 0);
        end

        // Signed overflow: saturating vs wrapping 16-bit accumulators.
        beat(8'd127, 8'd127, 1'b1, 1'b0, 1'b1);
        beat(8'd127, 8'd127, 1'b0, 1'b0, 1'b1);
        beat(8'd127, 8'd127, 1'b0, 1'b1, 1'b1);
        bubble(2);
        chk("t3_res32", res_o[0], 48387);
        chk("t3_ovf32", ov[0], 0);
        chk("t3_res16_sat", res_o[1], 32767);
        chk("t3_ovf16_sat", ov[1], 1);
        chk("t3_res16_wrap", res_o[2], 16'hBD03);
        chk("t3_ovf16_wrap", ov[2], 1);

        // Same vectors with two-cycle bubbles between beats.
        beat(8'd1, 8'd5, 1'b1, 1'b0, 1'b0);
        bubble(2);
        beat(8'd2, 8'd6, 1'b0, 1'b0, 1'b0);
        bubble(2);
        beat(8'd3, 8'd7, 1'b0, 1'b0, 1'b0);
        bubble(2);
        beat(8'd4, 8'd8, 1'b0, 1'b1, 1'b0);
        bubble(2);
        chk("t4_strobe", rv[0], 1);
        chk("t4_res", res_o[0], 70);
        bubble(4);
        chk("t4_res_hold", res_o[0], 70);
        chk("t4_a_hold", a_o[0], 4);
        chk("t4_b_hold", b_o[0], 8);

        // Reset in the middle of a dot product.
        beat(8'd1, 8'd5, 1'b1, 1'b0, 1'b0);
        beat(8'd2, 8'd6, 1'b0, 1'b1, 1'b0);
        valid_in = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_a_out", a_o[0], 0);
        chk("t5_b_out", b_o[0], 0);
        chk("t5_valid_out", vo[0], 0);
        chk("t5_res_out", res_o[0], 0);
        chk("t5_res_valid", rv[0], 0);
        chk("t5_ovf", ov[0], 0);
        bubble(3);
        chk("t5_no_stale_strobe", rv[0], 0);
        beat(8'd9, 8'd9, 1'b1, 1'b1, 1'b0);
        bubble(2);
        chk("t5_strobe", rv[0], 1);
        chk("t5_res", res_o[0], 81);

        // Back-to-back dot products.
        beat(8'd2, 8'd4, 1'b1, 1'b0, 1'b0);
        beat(8'd3, 8'd5, 1'b0, 1'b1, 1'b0);
        beat(8'd1, 8'd7, 1'b1, 1'b1, 1'b0);
        bubble(1);
        chk("t6_strobe_a", rv[0], 1);
        chk("t6_res_a", res_o[0], 23);
        bubble(1);
        chk("t6_strobe_b", rv[0], 1);
        chk("t6_res_b", res_o[0], 7);

        // Randomized dot products; the first after reset has no clear.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int d = 0; d < 80; d++) begin
            len  = $urandom_range(1, 6);
            rsgn = 1'($urandom_range(0, 1));
            big  = ($urandom_range(0, 3) == 0);
            for (int j = 0; j < len; j++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                if (big) begin
                    ra = rsgn ? ($urandom_range(0, 1) ? 8'd127 : 8'd128) : 8'($urandom_range(200, 255));
                    rb = rsgn ? ($urandom_range(0, 1) ? 8'd127 : 8'd128) : 8'($urandom_range(200, 255));
                end
                rclr = (j == 0) && (d != 0);
                beat(ra, rb, rclr, j == len - 1, rsgn);
                if ($urandom_range(0, 3) == 0) bubble($urandom_range(1, 2));
            end
        end
        bubble(5);
        chk("drain_pending", 64'(expq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_pe.md
Name: mac_pe

Overview:
Parametrised systolic processing element for the matrix-multiply array; successor to the basic 8-bit MAC.
- Forwards operands and a beat valid east/south with 1-cycle latency.
- Runs a 3-stage multiply-accumulate pipeline with signed/unsigned mode and optional saturation.
- Uses clear/last framing, so one PE computes back-to-back dot products without reset and emits a result strobe per dot product.

Parameters:
DATA_W, 8, operand width in bits
ACC_W, 32, accumulator/result width; must be >= 2*DATA_W (elaboration-time assertion)
SATURATE, 1, 1 = clamp on overflow; 0 = wrap modulo 2^ACC_W

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
a_in  in  DATA_W  operand A
b_in  in  DATA_W  operand B
valid_in  in  1  beat valid; a_in/b_in/clear_in/last_in/signed_in are meaningful only when high
clear_in  in  1  first beat of a dot product; accumulator restarts from this product
last_in  in  1  final beat of a dot product; its accumulation produces a result strobe
signed_in  in  1  1 = two's-complement operands, 0 = unsigned; applies to this beat only
a_out  out  DATA_W  forwarded A
b_out  out  DATA_W  forwarded B
valid_out  out  1  forwarded beat valid
clear_out  out  1  forwarded clear
last_out  out  1  forwarded last
signed_out  out  1  forwarded mode
res_out  out  ACC_W  accumulator value
res_valid  out  1  one-cycle strobe: res_out holds a completed dot product
ovf  out  1  sticky overflow flag for the current dot product

Behaviour:
Reset:
- All outputs and all internal pipeline registers go to 0.
- Reset mid-operation discards any in-flight beats and any partial sum.
- No res_valid is emitted for beats that entered before reset.

Forwarding path (stage 0):
- a_out/b_out load a_in/b_in only when valid_in = 1; they hold during bubbles.
- valid_out <= valid_in every cycle.
- clear_out, last_out and signed_out load valid_in & the corresponding input every cycle.

Pipeline timing (beat sampled at edge k):
- Edge k, stage 0: operands, mode and flags registered (these are the forwarding registers).
- Edge k+1, stage 1: product registered.
  - Signed: DATA_W x DATA_W two's-complement product, 2*DATA_W bits.
  - Unsigned: unsigned product.
- Edge k+2, stage 2: accumulate.
  - Product is sign-extended (signed) or zero-extended (unsigned) to ACC_W.
  - If clear: acc <= ext(product), and ovf <= overflow of this beat (always 0).
  - Otherwise: acc <= acc + ext(product), and ovf <= ovf | overflow.
- res_valid <= stage-2 valid & last, so res_valid is high in the cycle after edge k+2.
  - Latency from last beat to strobe is 3 cycles.
  - res_out is the acc register and holds until the next valid stage-2 beat.
- Each stage register updates only when that stage's valid is 1. Bubbles leave product and acc unchanged.
- Stage-1 and stage-2 valids are cleared on reset.

Overflow rules:
- Signed: overflow when both addends have the same sign and the sum's sign differs.
  - SATURATE=1 clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1).
- Unsigned: overflow on carry out of bit ACC_W-1.
  - SATURATE=1 clamps to 2^ACC_W-1.
- SATURATE=0: result wraps; ovf is still set.
- Mode is per beat. Mixing modes within one dot product is legal but undefined numerically; no check is performed.

Boundary conditions:
- clear & last on the same beat: single-product dot product.
- Accumulate without a prior clear after reset: sums from 0.
- A last beat followed immediately by a clear beat gives results in consecutive cycles with no cross-contamination.
- clear_in, last_in and signed_in are ignored when valid_in = 0.
- Full throughput: one beat per cycle, no backpressure.

Decomposition:
- Package mac_pkg holds:
  - stage-count constant MAC_LATENCY = 3;
  - packed struct beat_t {valid, clear, last, is_signed};
  - functions sat_max(ACC_W, is_signed) and sat_min(ACC_W, is_signed).
- One sub-module, mac_acc_sat, holds stage 2 combinationally:
  - inputs: acc, extended product, clear, is_signed;
  - outputs: next acc and the overflow bit.
  - SATURATE is passed down as a parameter.

Test Plan:
1. Default params, unsigned, contiguous beats a=[1,2,3,4], b=[5,6,7,8], clear on beat 0, last on beat 3 -> single res_valid pulse 3 cycles after beat 3; res_out = 70; ovf = 0; a_out/b_out lag a_in/b_in by exactly 1 cycle.
2. Single beat a=0xFD, b=5, clear & last -> signed_in=1 gives res_out = 0xFFFFFFF1 (-15); repeat with signed_in=0 -> res_out = 1265.
3. ACC_W=16, SATURATE=1, signed, three beats 127*127 -> res_out = 32767, ovf = 1; same run with SATURATE=0 -> res_out = 48387 mod 65536 (0xBD03), ovf = 1.
4. Test 1 vectors with 2-cycle bubbles between beats -> res_out = 70, single strobe; during bubbles res_out, a_out and b_out hold and valid_out = 0.
5. Reset for 1 cycle after 2 beats of test 1 -> next cycle all outputs 0, no res_valid; then clear & last beat 9*9 -> res_out = 81.
6. Back-to-back dot products: [2,3]·[4,5] (last) then immediately [1]·[7] (clear & last) -> res_valid in two consecutive cycles, res_out = 23 then 7.
